// File: rtl/axi4_lite_fifo_bridge.sv
// AXI4-Lite slave that splits requests into external AW/W/AR FIFOs and merges B/R responses
// back in issue order, answering out-of-window accesses locally with DECERR.

module axi4_lite_fifo_bridge_tagq #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic head_valid,
  output logic head_tag
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DEPTH-1:0] tag_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  assign full       = (count_reg == CNT_W'(DEPTH));
  assign head_valid = (count_reg != '0);
  assign head_tag   = tag_reg[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        tag_reg[wr_ptr_reg] <= push_tag;
        wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

module axi4_lite_fifo_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MAX_OUT = 4,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_W:0] ADDR_SIZE = (ADDR_W+1)'(4096)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDR_W-1:0]        s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [DATA_W-1:0]        s_axi_wdata,
  input  logic [DATA_W/8-1:0]      s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_W-1:0]        s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [DATA_W-1:0]        s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [ADDR_W-1:0]        aw_fifo_wdata,
  output logic                     aw_fifo_wen,
  input  logic                     aw_fifo_full,
  output logic [DATA_W+DATA_W/8-1:0] w_fifo_wdata,
  output logic                     w_fifo_wen,
  input  logic                     w_fifo_full,
  output logic [ADDR_W-1:0]        ar_fifo_wdata,
  output logic                     ar_fifo_wen,
  input  logic                     ar_fifo_full,
  input  logic [DATA_W+1:0]        r_fifo_rdata,
  output logic                     r_fifo_ren,
  input  logic                     r_fifo_empty,
  input  logic [1:0]               b_fifo_rdata,
  output logic                     b_fifo_ren,
  input  logic                     b_fifo_empty
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] DECERR = 2'b11;

  // Extra top bit keeps BASE+SIZE from wrapping at the top of the address space.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] a;
    logic [ADDR_W:0] lo;
    logic [ADDR_W:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, ADDR_BASE};
    hi = lo + ADDR_SIZE;
    return (a >= lo) && (a < hi);
  endfunction

  // ---------------- write path ----------------
  logic              aw_held_reg;
  logic [ADDR_W-1:0] aw_addr_reg;
  logic              w_held_reg;
  logic [DATA_W-1:0] w_data_reg;
  logic [STRB_W-1:0] w_strb_reg;
  logic              bvalid_reg;
  logic [1:0]        bresp_reg;

  logic aw_in_win;
  logic w_issue;
  logic wq_full;
  logic wq_head_valid;
  logic wq_head_tag;
  logic b_load;

  assign aw_in_win = in_window(aw_addr_reg);
  assign b_load    = wq_head_valid && (!bvalid_reg || s_axi_bready) &&
                     (wq_head_tag || !b_fifo_empty);
  // A retire in the same cycle frees the slot, so a full queue may still accept.
  assign w_issue   = aw_held_reg && w_held_reg && (!wq_full || b_load) &&
                     (!aw_in_win || (!aw_fifo_full && !w_fifo_full));

  assign s_axi_awready = !aw_held_reg;
  assign s_axi_wready  = !w_held_reg;
  assign aw_fifo_wen   = w_issue && aw_in_win;
  assign w_fifo_wen    = w_issue && aw_in_win;
  assign aw_fifo_wdata = aw_addr_reg;
  assign w_fifo_wdata  = {w_strb_reg, w_data_reg};
  assign b_fifo_ren    = b_load && !wq_head_tag;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = bresp_reg;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held_reg <= 1'b0;
      aw_addr_reg <= '0;
    end else if (w_issue) begin
      aw_held_reg <= 1'b0;
    end else if (s_axi_awvalid && !aw_held_reg) begin
      aw_held_reg <= 1'b1;
      aw_addr_reg <= s_axi_awaddr;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_held_reg <= 1'b0;
      w_data_reg <= '0;
      w_strb_reg <= '0;
    end else if (w_issue) begin
      w_held_reg <= 1'b0;
    end else if (s_axi_wvalid && !w_held_reg) begin
      w_held_reg <= 1'b1;
      w_data_reg <= s_axi_wdata;
      w_strb_reg <= s_axi_wstrb;
    end
  end

  axi4_lite_fifo_bridge_tagq #(.DEPTH(MAX_OUT)) u_wq (
    .clk        (aclk),
    .rst        (areset),
    .push       (w_issue),
    .push_tag   (!aw_in_win),
    .pop        (b_load),
    .full       (wq_full),
    .head_valid (wq_head_valid),
    .head_tag   (wq_head_tag)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bvalid_reg <= 1'b0;
      bresp_reg  <= 2'b00;
    end else if (b_load) begin
      bvalid_reg <= 1'b1;
      bresp_reg  <= wq_head_tag ? DECERR : b_fifo_rdata;
    end else if (s_axi_bready) begin
      bvalid_reg <= 1'b0;
    end
  end

  // ---------------- read path ----------------
  logic              ar_held_reg;
  logic [ADDR_W-1:0] ar_addr_reg;
  logic              rvalid_reg;
  logic [1:0]        rresp_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic ar_in_win;
  logic r_issue;
  logic rq_full;
  logic rq_head_valid;
  logic rq_head_tag;
  logic r_load;

  assign ar_in_win = in_window(ar_addr_reg);
  assign r_load    = rq_head_valid && (!rvalid_reg || s_axi_rready) &&
                     (rq_head_tag || !r_fifo_empty);
  assign r_issue   = ar_held_reg && (!rq_full || r_load) &&
                     (!ar_in_win || !ar_fifo_full);

  assign s_axi_arready = !ar_held_reg;
  assign ar_fifo_wen   = r_issue && ar_in_win;
  assign ar_fifo_wdata = ar_addr_reg;
  assign r_fifo_ren    = r_load && !rq_head_tag;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rresp   = rresp_reg;
  assign s_axi_rdata   = rdata_reg;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ar_held_reg <= 1'b0;
      ar_addr_reg <= '0;
    end else if (r_issue) begin
      ar_held_reg <= 1'b0;
    end else if (s_axi_arvalid && !ar_held_reg) begin
      ar_held_reg <= 1'b1;
      ar_addr_reg <= s_axi_araddr;
    end
  end

  axi4_lite_fifo_bridge_tagq #(.DEPTH(MAX_OUT)) u_rq (
    .clk        (aclk),
    .rst        (areset),
    .push       (r_issue),
    .push_tag   (!ar_in_win),
    .pop        (r_load),
    .full       (rq_full),
    .head_valid (rq_head_valid),
    .head_tag   (rq_head_tag)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid_reg <= 1'b0;
      rresp_reg  <= 2'b00;
      rdata_reg  <= '0;
    end else if (r_load) begin
      rvalid_reg <= 1'b1;
      rresp_reg  <= rq_head_tag ? DECERR : r_fifo_rdata[DATA_W+1:DATA_W];
      rdata_reg  <= rq_head_tag ? '0 : r_fifo_rdata[DATA_W-1:0];
    end else if (s_axi_rready) begin
      rvalid_reg <= 1'b0;
    end
  end
endmodule
